// File: rtl/devtbl_enum.sv
// Device-table enumerator: reads DevID and DevMapSz/DevUseIntr per entry over pi1, assigns packed base addresses.
// Define DEVTBL_ENUM_INTRIDX_EN to add sequential interrupt-index allocation (dev_intridx_flat_o, intrcnt_o).
module devtbl_enum #(
    parameter int ARCHBITSZ = 16,
    parameter int DEVMAPCNT = 2,
    parameter bit AUTOSTART = 1'b1,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8),
    localparam int CNTW      = $clog2(DEVMAPCNT+1),
    localparam int IDXW      = (DEVMAPCNT > 1) ? $clog2(DEVMAPCNT) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [CNTW-1:0]                devcnt_o,
    output logic [1:0]                     m_op_o,
    output logic [ADDRBITSZ-1:0]           m_addr_o,
    input  logic [ARCHBITSZ-1:0]           m_data_i,
    input  logic                           m_rdy_i,
`ifdef DEVTBL_ENUM_INTRIDX_EN
    output logic [IDXW*DEVMAPCNT-1:0]      dev_intridx_flat_o,
    output logic [CNTW-1:0]                intrcnt_o,
`endif
    output logic [ARCHBITSZ*DEVMAPCNT-1:0] dev_id_flat_o,
    output logic [ADDRBITSZ*DEVMAPCNT-1:0] dev_base_flat_o,
    output logic [ADDRBITSZ*DEVMAPCNT-1:0] dev_mapsz_flat_o,
    output logic [DEVMAPCNT-1:0]           dev_useintr_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQID, S_WAITID, S_REQSZ, S_WAITSZ, S_DONE
    } state_t;

    localparam logic [1:0] PINOOP = 2'd0;
    localparam logic [1:0] PIRDOP = 2'd2;
    localparam int         SZLSB  = ARCHBITSZ - ADDRBITSZ;

    state_t               state_q, state_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [ADDRBITSZ-1:0] acc_q, acc_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 auto_q, auto_d;

    logic                 id_we, sz_we, zero_we, entry_end, last_idx;
    logic [ADDRBITSZ-1:0] mapsz;
    logic [ADDRBITSZ:0]   sum;

    logic [ARCHBITSZ-1:0] id_q   [DEVMAPCNT];
    logic [ADDRBITSZ-1:0] base_q [DEVMAPCNT];
    logic [ADDRBITSZ-1:0] size_q [DEVMAPCNT];
    logic [DEVMAPCNT-1:0] useintr_q;

`ifdef DEVTBL_ENUM_INTRIDX_EN
    logic [CNTW-1:0]      icnt_q, icnt_d;
    logic [IDXW-1:0]      intridx_q [DEVMAPCNT];
`else
    // Interrupt indices are not allocated in this build.
`endif

    // The size word carries a byte count; dropping the byte-offset bits yields words.
    assign mapsz    = m_data_i[ARCHBITSZ-1:SZLSB];
    assign sum      = {1'b0, acc_q} + {1'b0, mapsz};
    assign last_idx = (idx_q == IDXW'(DEVMAPCNT-1));

    // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = done_q;
        auto_d    = auto_q;
        id_we     = 1'b0;
        sz_we     = 1'b0;
        zero_we   = 1'b0;
        entry_end = 1'b0;
        m_op_o    = PINOOP;
        m_addr_o  = '0;
`ifdef DEVTBL_ENUM_INTRIDX_EN
        icnt_d    = icnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i || auto_q) begin
                    state_d = S_REQID;
                    idx_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    auto_d  = 1'b0;
`ifdef DEVTBL_ENUM_INTRIDX_EN
                    icnt_d  = '0;
`endif
                end
            end
            S_REQID: begin
                m_op_o   = PIRDOP;
                m_addr_o = ADDRBITSZ'({idx_q, 1'b0});
                if (m_rdy_i) state_d = S_WAITID;
            end
            S_WAITID: begin
                if (m_data_i == '0) begin
                    zero_we   = 1'b1;
                    entry_end = 1'b1;
                end else begin
                    id_we   = 1'b1;
                    state_d = S_REQSZ;
                end
            end
            S_REQSZ: begin
                m_op_o   = PIRDOP;
                m_addr_o = ADDRBITSZ'({idx_q, 1'b1});
                if (m_rdy_i) state_d = S_WAITSZ;
            end
            S_WAITSZ: begin
                sz_we     = 1'b1;
                entry_end = 1'b1;
                acc_d     = sum[ADDRBITSZ-1:0];
                err_d     = err_q | sum[ADDRBITSZ];
                cnt_d     = cnt_q + CNTW'(1);
`ifdef DEVTBL_ENUM_INTRIDX_EN
                if (m_data_i[0]) icnt_d = icnt_q + CNTW'(1);
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (entry_end) begin
            if (last_idx) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + IDXW'(1);
                state_d = S_REQID;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            auto_q  <= AUTOSTART;
`ifdef DEVTBL_ENUM_INTRIDX_EN
            icnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            auto_q  <= auto_d;
`ifdef DEVTBL_ENUM_INTRIDX_EN
            icnt_q  <= icnt_d;
`endif
        end
    end

    // NOTE: the tables are reset, unlike a plain RAM, because decoders read them directly as outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEVMAPCNT; i++) begin
                id_q[i]   <= '0;
                base_q[i] <= '0;
                size_q[i] <= '0;
`ifdef DEVTBL_ENUM_INTRIDX_EN
                intridx_q[i] <= '0;
`endif
            end
            useintr_q <= '0;
        end else begin
            if (zero_we) begin
                id_q[idx_q]      <= '0;
                base_q[idx_q]    <= '0;
                size_q[idx_q]    <= '0;
                useintr_q[idx_q] <= 1'b0;
`ifdef DEVTBL_ENUM_INTRIDX_EN
                intridx_q[idx_q] <= '0;
`endif
            end
            if (id_we) id_q[idx_q] <= m_data_i;
            if (sz_we) begin
                base_q[idx_q]    <= acc_q;
                size_q[idx_q]    <= mapsz;
                useintr_q[idx_q] <= m_data_i[0];
`ifdef DEVTBL_ENUM_INTRIDX_EN
                intridx_q[idx_q] <= m_data_i[0] ? IDXW'(icnt_q) : '0;
`endif
            end
        end
    end

    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign devcnt_o      = cnt_q;
    assign dev_useintr_o = useintr_q;
`ifdef DEVTBL_ENUM_INTRIDX_EN
    assign intrcnt_o     = icnt_q;
`endif

    for (genvar g = 0; g < DEVMAPCNT; g++) begin : g_flat
        assign dev_id_flat_o[g*ARCHBITSZ +: ARCHBITSZ]    = id_q[g];
        assign dev_base_flat_o[g*ADDRBITSZ +: ADDRBITSZ]  = base_q[g];
        assign dev_mapsz_flat_o[g*ADDRBITSZ +: ADDRBITSZ] = size_q[g];
`ifdef DEVTBL_ENUM_INTRIDX_EN
        assign dev_intridx_flat_o[g*IDXW +: IDXW]         = intridx_q[g];
`endif
    end

endmodule
